// File: rtl/alu_exec.sv
// alu_exec: two-stage pipelined RV32I ALU/branch/jump execute unit feeding the execute CDB.
//   clk, rst (async, active-low), rdy (global enable)
//   exe_RS_*    : one issued instruction per cycle from the reservation station
//   rob_clear   : misprediction flush, drops everything in flight
//   ex_cdb_*    : registered result broadcast (flag, tag, value, jump, target)
module alu_exec #(
  parameter int XLEN  = 32,
  parameter int ROBBW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             exe_RS_flag,
  input  logic [XLEN-1:0]  exe_RS_V1,
  input  logic [XLEN-1:0]  exe_RS_V2,
  input  logic [XLEN-1:0]  exe_RS_A,
  input  logic [XLEN-1:0]  exe_RS_pc,
  input  logic [5:0]       exe_RS_code,
  input  logic [ROBBW-1:0] exe_RS_rob_id,
  input  logic             rob_clear,
  output logic             ex_cdb_flag,
  output logic [ROBBW-1:0] ex_cdb_rob_id,
  output logic [XLEN-1:0]  ex_cdb_val,
  output logic             ex_cdb_jump,
  output logic [XLEN-1:0]  ex_cdb_target
);
  localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4,
                         BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10,
                         ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22, ORI = 6'd23,
                         ANDI = 6'd24, SLLI = 6'd25, SRLI = 6'd26, SRAI = 6'd27,
                         ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32,
                         XOR = 6'd33, SRL = 6'd34, SRA = 6'd35, OR = 6'd36, AND = 6'd37;
  logic             s1_v_q, flag_q, jump_q, jump_d, lt, ltu, eq, tk;
  logic [5:0]       code_q;
  logic [XLEN-1:0]  v1_q, b_q, a_q, pc_q, b_d, val_q, val_d, tgt_q, tgt_d, pc4, pca, jr;
  logic [ROBBW-1:0] rob_q, id_q;
  logic [4:0]       sh;
  // I-type ALU ops, LUI and AUIPC take the immediate as operand B; R-type and branches take V2
  assign b_d = ((exe_RS_code >= ADDI && exe_RS_code <= SRAI) || exe_RS_code == LUI || exe_RS_code == AUIPC)
               ? exe_RS_A : exe_RS_V2;
  assign pc4 = pc_q + XLEN'(4);
  assign pca = pc_q + a_q;
  assign jr  = v1_q + a_q;
  assign sh  = b_q[4:0];
  assign eq  = v1_q == b_q;
  assign lt  = $signed(v1_q) < $signed(b_q);
  assign ltu = v1_q < b_q;
  assign tk  = code_q == BEQ  ? eq   : code_q == BNE  ? !eq :
               code_q == BLT  ? lt   : code_q == BGE  ? !lt :
               code_q == BLTU ? ltu  : !ltu;
  always_comb begin
    val_d  = '0;
    jump_d = 1'b0;
    tgt_d  = pc4;
    case (code_q)
      LUI:                           val_d = a_q;
      AUIPC:                         val_d = pca;
      JAL:                           begin val_d = pc4; jump_d = 1'b1; tgt_d = pca; end
      JALR:                          begin val_d = pc4; jump_d = 1'b1; tgt_d = {jr[XLEN-1:1], 1'b0}; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin val_d = {{(XLEN-1){1'b0}}, tk}; jump_d = tk; tgt_d = tk ? pca : pc4; end
      ADD, ADDI:                     val_d = v1_q + b_q;
      SUB:                           val_d = v1_q - b_q;
      SLL, SLLI:                     val_d = v1_q << sh;
      SLT, SLTI:                     val_d = {{(XLEN-1){1'b0}}, lt};
      SLTU, SLTIU:                   val_d = {{(XLEN-1){1'b0}}, ltu};
      XOR, XORI:                     val_d = v1_q ^ b_q;
      SRL, SRLI:                     val_d = v1_q >> sh;
      SRA, SRAI:                     val_d = $signed(v1_q) >>> sh;
      OR, ORI:                       val_d = v1_q | b_q;
      AND, ANDI:                     val_d = v1_q & b_q;
      default:                       val_d = '0;
    endcase
  end
  // Output data only moves when a live result arrives, so it holds (never X) while the flag is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0;
      code_q <= '0;
      v1_q   <= '0;
      b_q    <= '0;
      a_q    <= '0;
      pc_q   <= '0;
      rob_q  <= '0;
      flag_q <= 1'b0;
      id_q   <= '0;
      val_q  <= '0;
      jump_q <= 1'b0;
      tgt_q  <= '0;
    end else if (rdy) begin
      s1_v_q <= exe_RS_flag && !rob_clear;
      if (exe_RS_flag) begin
        code_q <= exe_RS_code;
        v1_q   <= exe_RS_V1;
        b_q    <= b_d;
        a_q    <= exe_RS_A;
        pc_q   <= exe_RS_pc;
        rob_q  <= exe_RS_rob_id;
      end
      flag_q <= s1_v_q && !rob_clear;
      if (s1_v_q && !rob_clear) begin
        id_q   <= rob_q;
        val_q  <= val_d;
        jump_q <= jump_d;
        tgt_q  <= tgt_d;
      end
    end
  end
  assign ex_cdb_flag   = flag_q;
  assign ex_cdb_rob_id = id_q;
  assign ex_cdb_val    = val_q;
  assign ex_cdb_jump   = jump_q;
  assign ex_cdb_target = tgt_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
module tb_alu_exec;
  localparam logic [5:0] JALR = 6'd4, BLT = 6'd7, BLTU = 6'd9, ADDI = 6'd19,
                         ADD = 6'd28, SRA = 6'd35, BAD = 6'd63;
  logic        clk = 1'b0, rst, rdy, flag, clr;
  logic [31:0] v1, v2, a, pc;
  logic [5:0]  code;
  logic [3:0]  id;
  logic        o_flag, o_jump;
  logic [3:0]  o_id;
  logic [31:0] o_val, o_tgt;
  int          tests = 0, fails = 0;
  alu_exec #(.XLEN(32), .ROBBW(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .exe_RS_flag(flag), .exe_RS_V1(v1), .exe_RS_V2(v2),
    .exe_RS_A(a), .exe_RS_pc(pc), .exe_RS_code(code), .exe_RS_rob_id(id), .rob_clear(clr),
    .ex_cdb_flag(o_flag), .ex_cdb_rob_id(o_id), .ex_cdb_val(o_val), .ex_cdb_jump(o_jump),
    .ex_cdb_target(o_tgt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] imm, input logic [31:0] p, input logic [3:0] t);
    flag = 1'b1; code = c; v1 = x; v2 = y; a = imm; pc = p; id = t;
  endtask
  task automatic idle();
    flag = 1'b0; code = '0; v1 = '0; v2 = '0; a = '0; pc = '0; id = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0; rdy = 1'b1; clr = 1'b0;
    idle();
    #3;
    chk("rst_flag", {31'b0, o_flag}, 32'd0);
    chk("rst_id", {28'b0, o_id}, 32'd0);
    chk("rst_val", o_val, 32'd0);
    chk("rst_jump", {31'b0, o_jump}, 32'd0);
    chk("rst_tgt", o_tgt, 32'd0);
    tick();
    rst = 1'b1;
    issue(ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 4'd3);
    tick();
    issue(SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd4);
    tick();
    chk("add_flag", {31'b0, o_flag}, 32'd1);
    chk("add_val", o_val, 32'h0000_0001);
    chk("add_id", {28'b0, o_id}, 32'd3);
    chk("add_jump", {31'b0, o_jump}, 32'd0);
    chk("add_tgt", o_tgt, 32'd4);
    idle();
    tick();
    chk("sra_flag", {31'b0, o_flag}, 32'd1);
    chk("sra_val", o_val, 32'hF800_0000);
    chk("sra_id", {28'b0, o_id}, 32'd4);
    tick();
    chk("pulse_end_flag", {31'b0, o_flag}, 32'd0);
    chk("hold_val", o_val, 32'hF800_0000);
    issue(BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5);
    tick();
    issue(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
    tick();
    chk("blt_flag", {31'b0, o_flag}, 32'd1);
    chk("blt_jump", {31'b0, o_jump}, 32'd1);
    chk("blt_tgt", o_tgt, 32'h120);
    chk("blt_val", o_val, 32'd1);
    idle();
    tick();
    chk("bltu_flag", {31'b0, o_flag}, 32'd1);
    chk("bltu_id", {28'b0, o_id}, 32'd6);
    chk("bltu_jump", {31'b0, o_jump}, 32'd0);
    chk("bltu_tgt", o_tgt, 32'h104);
    chk("bltu_val", o_val, 32'd0);
    issue(JALR, 32'h1001, 32'd0, 32'h4, 32'h40, 4'd7);
    tick();
    idle();
    tick();
    chk("jalr_val", o_val, 32'h44);
    chk("jalr_jump", {31'b0, o_jump}, 32'd1);
    chk("jalr_tgt", o_tgt, 32'h1004);
    issue(BAD, 32'd5, 32'd6, 32'd7, 32'h200, 4'd8);
    tick();
    idle();
    tick();
    chk("bad_flag", {31'b0, o_flag}, 32'd1);
    chk("bad_val", o_val, 32'd0);
    chk("bad_jump", {31'b0, o_jump}, 32'd0);
    chk("bad_tgt", o_tgt, 32'h204);
    tick();
    issue(ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);
    tick();
    issue(ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("flush_flag1", {31'b0, o_flag}, 32'd0);
    issue(ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd11);
    tick();
    chk("flush_flag2", {31'b0, o_flag}, 32'd0);
    idle();
    tick();
    chk("post_flush_flag", {31'b0, o_flag}, 32'd1);
    chk("post_flush_id", {28'b0, o_id}, 32'd11);
    chk("post_flush_val", o_val, 32'd6);
    tick();
    chk("post_flush_end", {31'b0, o_flag}, 32'd0);
    issue(ADDI, 32'd5, 32'd100, 32'd7, 32'd0, 4'd12);
    tick();
    idle();
    tick();
    chk("addi_val", o_val, 32'd12);
    rdy = 1'b0;
    clr = 1'b1;
    issue(ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd13);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flag", {31'b0, o_flag}, 32'd1);
      chk("stall_val", o_val, 32'd12);
      chk("stall_id", {28'b0, o_id}, 32'd12);
    end
    rdy = 1'b1;
    clr = 1'b0;
    idle();
    tick();
    chk("unstall_flag", {31'b0, o_flag}, 32'd0);
    tick();
    chk("stall_issue_dropped", {31'b0, o_flag}, 32'd0);
    issue(ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd14);
    tick();
    issue(ADD, 32'd3, 32'd4, 32'd0, 32'd0, 4'd15);
    tick();
    idle();
    chk("pre_rst_val", o_val, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_flag", {31'b0, o_flag}, 32'd0);
    chk("arst_val", o_val, 32'd0);
    chk("arst_id", {28'b0, o_id}, 32'd0);
    chk("arst_tgt", o_tgt, 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("after_rst_flag1", {31'b0, o_flag}, 32'd0);
    tick();
    chk("after_rst_flag2", {31'b0, o_flag}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
